// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control unit: FSM state encoding,
// keypad code map and default register-bank addresses.
package calc_pkg;

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WR_A    = 3'd1,
    S_WAIT_OP = 3'd2,
    S_WAIT_B  = 3'd3,
    S_WR_B    = 3'd4,
    S_WAIT_EN = 3'd5,
    S_EXEC    = 3'd6
  } state_t;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_ENTER     = 4'hA;
  localparam logic [3:0] KEY_OP_MIN    = 4'hB;
  localparam logic [3:0] KEY_OP_MAX    = 4'hE;
  localparam logic [3:0] KEY_CLEAR     = 4'hF;

  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_REG_A   = 1;
  localparam int DEF_REG_B   = 2;
  localparam int DEF_REG_RES = 3;

endpackage

// File: rtl/calc_control_unit_key_classifier.sv
// Combinational decode of a keypad code into digit / operator / Enter / Clear classes.
module key_classifier
  import calc_pkg::*;
(
  input  logic [3:0] key_i,
  output logic       is_digit_o,
  output logic       is_op_o,
  output logic       is_enter_o,
  output logic       is_clear_o
);

  assign is_digit_o = (key_i <= KEY_DIGIT_MAX);
  assign is_op_o    = (key_i >= KEY_OP_MIN) && (key_i <= KEY_OP_MAX);
  assign is_enter_o = (key_i == KEY_ENTER);
  assign is_clear_o = (key_i == KEY_CLEAR);

endmodule

// File: rtl/calc_control_unit.sv
// Keypad-driven control FSM for the calculator datapath: A, operator, B, Enter -> one ALU write.
// Optional macro CALC_CHAIN_RESULT_EN: operator in WAIT_A reuses the last result as operand A.
module calc_control_unit
  import calc_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int REG_A   = DEF_REG_A,
  parameter int REG_B   = DEF_REG_B,
  parameter int REG_RES = DEF_REG_RES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tecla_valid_i,
  input  logic [3:0]        teclado_i,
  output logic              mux_sel,
  output logic [ADDR_W-1:0] addr_rs1,
  output logic [ADDR_W-1:0] addr_rs2,
  output logic [ADDR_W-1:0] addr_rd,
  output logic              we_banco,
  output logic [3:0]        op_alu,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] A_ADDR   = ADDR_W'(REG_A);
  localparam logic [ADDR_W-1:0] B_ADDR   = ADDR_W'(REG_B);
  localparam logic [ADDR_W-1:0] RES_ADDR = ADDR_W'(REG_RES);

  logic is_digit, is_op, is_enter, is_clear;

  key_classifier u_cls (
    .key_i      (teclado_i),
    .is_digit_o (is_digit),
    .is_op_o    (is_op),
    .is_enter_o (is_enter),
    .is_clear_o (is_clear)
  );

  state_t            state_q, state_d;
  logic [3:0]        opcode_q, opcode_d;
  logic              chain_q, chain_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic              mux_q, mux_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [3:0]        op_q, op_d;

  // Next-state decision: write/exec states are single-cycle and drop any strobe.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    chain_d  = chain_q;
    err_d    = 1'b0;
    case (state_q)
      S_WR_A: begin
        state_d = S_WAIT_OP;
        err_d   = tecla_valid_i;
      end
      S_WR_B: begin
        state_d = S_WAIT_EN;
        err_d   = tecla_valid_i;
      end
      S_EXEC: begin
        state_d = S_WAIT_A;
        chain_d = 1'b0;
        err_d   = tecla_valid_i;
      end
      default: begin
        if (tecla_valid_i) begin
          if (is_clear) begin
            state_d  = S_WAIT_A;
            opcode_d = 4'h0;
            chain_d  = 1'b0;
          end else begin
            case (state_q)
              S_WAIT_A: begin
                if (is_digit) state_d = S_WR_A;
`ifdef CALC_CHAIN_RESULT_EN
                else if (is_op) begin
                  chain_d  = 1'b1;
                  opcode_d = teclado_i;
                  state_d  = S_WAIT_B;
                end
`endif
                else err_d = 1'b1;
              end
              S_WAIT_OP: begin
                if (is_op) begin
                  opcode_d = teclado_i;
                  state_d  = S_WAIT_B;
                end else err_d = 1'b1;
              end
              S_WAIT_B: begin
                if (is_digit) state_d = S_WR_B;
                else err_d = 1'b1;
              end
              S_WAIT_EN: begin
                if (is_enter) state_d = S_EXEC;
                else err_d = 1'b1;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
      end
    endcase
  end

  // Outputs are a function of the state being entered, so they are registered with it.
  always_comb begin
    we_d  = 1'b0;
    mux_d = 1'b0;
    rd_d  = '0;
    rs1_d = A_ADDR;
    rs2_d = RES_ADDR;
    op_d  = 4'h0;
    case (state_d)
      S_WR_A: begin
        we_d = 1'b1;
        rd_d = A_ADDR;
      end
      S_WAIT_OP, S_WAIT_B: rs2_d = A_ADDR;
      S_WR_B: begin
        we_d  = 1'b1;
        rd_d  = B_ADDR;
        rs2_d = A_ADDR;
      end
      S_WAIT_EN: rs2_d = B_ADDR;
      S_EXEC: begin
        we_d  = 1'b1;
        mux_d = 1'b1;
        rd_d  = RES_ADDR;
        rs1_d = chain_q ? RES_ADDR : A_ADDR;
        rs2_d = B_ADDR;
        op_d  = opcode_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_WAIT_A;
      opcode_q <= 4'h0;
      chain_q  <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      mux_q    <= 1'b0;
      rd_q     <= '0;
      rs1_q    <= A_ADDR;
      rs2_q    <= RES_ADDR;
      op_q     <= 4'h0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      chain_q  <= chain_d;
      err_q    <= err_d;
      we_q     <= we_d;
      mux_q    <= mux_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      op_q     <= op_d;
    end
  end

  assign mux_sel  = mux_q;
  assign addr_rs1 = rs1_q;
  assign addr_rs2 = rs2_q;
  assign addr_rd  = rd_q;
  assign we_banco = we_q;
  assign op_alu   = op_q;
  assign err_o    = err_q;

endmodule
